score_scan_driver: RTL and testbench
====================================

# score_scan_driver

Scan-side driver for the 4-bit indexed sprite readers (score article, digits, banners). It generates VGA timing and drives each sprite reader's request (`is_in_pixel`, sprite-local `hc`/`vc`). It samples the returned 4-bit palette index and emits registered 12-bit RGB with hsync/vsync, aligned to the same pixel tick. It sits between the top-level VGA pins and one sprite reader instance.

## Interface
Parameters:
- `CLK_DIV`, 2 — CLK cycles per pixel tick (50 MHz → 25 MHz).
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48 — horizontal timing, in ticks.
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33 — vertical timing, in lines.
- `SPR_X`, 0; `SPR_Y`, 0 — screen origin of the sprite window.
- `SPR_W`, 88; `SPR_H`, 20 — window size in screen pixels (22×5 sprite at 4× scale).
- `BG_RGB`, 12'h000 — colour for index 0 and for active area outside the window.

Ports:
- `CLK` in 1 — system clock.
- `RST_N` in 1 — asynchronous, active-low reset.
- `pixel` in 4 — palette index returned combinationally by the sprite reader.
- `hc` out 10 — sprite-local x (screen x − `SPR_X`); 0 outside the window.
- `vc` out 10 — sprite-local y (screen y − `SPR_Y`); 0 outside the window.
- `is_in_pixel` out 1 — current scan position lies inside the sprite window.
- `hsync` out 1 — horizontal sync, active low, registered.
- `vsync` out 1 — vertical sync, active low, registered.
- `video_on` out 1 — registered active-area flag.
- `rgb` out 12 — registered colour {R4,G4,B4}.
- `frame_start` out 1 — one-CLK pulse on the tick where h=0, v=0 is presented at the outputs.

## Operation
- Tick divider: a counter runs 0..`CLK_DIV`−1 and asserts `tick` at `CLK_DIV`−1, then wraps. With `CLK_DIV`=1, `tick` is high every cycle.
- Horizontal counter `h`: runs 0..H_TOTAL−1 (800), advancing on `tick`. It wraps to 0 and raises `h_wrap`.
- Vertical counter `v`: runs 0..V_TOTAL−1 (525), advancing on `tick && h_wrap`. It wraps to 0.
- Window test (combinational from `h`/`v`): `is_in_pixel` = (`SPR_X` ≤ h < `SPR_X`+`SPR_W`) and (`SPR_Y` ≤ v < `SPR_Y`+`SPR_H`) and the position is in the active area.
  - Inside the window: `hc` = h−`SPR_X`, `vc` = v−`SPR_Y`, both 10-bit.
  - Outside the window: `hc` = `vc` = 0.
- Output stage, updated only on `tick`:
  - `hsync` = !(H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC).
  - `vsync` is the same rule applied to `v` with the vertical parameters.
  - `video_on` = (h < H_ACTIVE) and (v < V_ACTIVE).
  - `rgb`:
    - 0 when not active.
    - `BG_RGB` when active and outside the window, or when the index is 0.
    - Otherwise PALETTE[`pixel`].
- `frame_start` is asserted for one CLK on the output update where the sampled h=0 and v=0.

## Timing
- Reset values: divider=0, h=0, v=0, `hsync`=1, `vsync`=1, `video_on`=0, `rgb`=0, `frame_start`=0. `hc`, `vc` and `is_in_pixel` follow from h=v=0: with default origin `is_in_pixel`=1 and `hc`=`vc`=0.
- First `tick` occurs `CLK_DIV` cycles after `RST_N` rises.
- Request-to-colour latency is exactly one tick:
  - `pixel` is sampled on the tick that also advances h.
  - `rgb`, syncs and `video_on` describe the same (h, v) and are mutually aligned.
- `pixel` must settle within one CLK of `hc`/`vc` changing; the sprite reader is combinational.
- Between ticks all registered outputs hold their value.
- Line wrap and frame wrap fall on the same tick: h→0 and v→0 together, no extra cycle.
- Reset asserted mid-frame: all state clears immediately, independent of `CLK`; the scan restarts at (0, 0).

## Structure
- Shared package `vga_pkg`:
  - the 16×12-bit PALETTE constant;
  - default 640×480 timing constants;
  - derived H_TOTAL and V_TOTAL.
- One sub-module: `vga_timing_gen`, containing the divider, the h/v counters, the `tick` and `h_wrap` outputs, and the raw sync/active decodes.
- Window mapping, palette lookup and the output registers live in `score_scan_driver`.

## Test plan
- Reset hold, then release:
  - while held: `hsync`=`vsync`=1, `rgb`=0, `video_on`=0;
  - after release: first `tick` at cycle `CLK_DIV`;
  - h=1 on the second tick.
- Free-run one line:
  - 800 ticks per line;
  - `hsync` low for exactly 96 ticks, starting one tick after the tick where h=656 is sampled;
  - `video_on` high for 640 ticks.
- Free-run one frame:
  - 525 lines;
  - `vsync` low during lines 490–491;
  - `frame_start` pulses once per 420000 ticks.
- `SPR_X`=100, `SPR_Y`=50, `pixel` forced to 4'hF at h=105, v=56:
  - `hc`=5, `vc`=6, `is_in_pixel`=1;
  - next tick `rgb` = PALETTE[15].
- h=99 or h=188 at v=56 (just outside the window):
  - `is_in_pixel`=0 and `hc`=`vc`=0;
  - `rgb`=`BG_RGB` one tick later.
- `RST_N` pulsed low for 3 cycles at h=400, v=200:
  - outputs return to reset values asynchronously;
  - scan resumes from (0, 0) with correct line length.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, derived totals and the
// 16-entry 12-bit palette used to colour 4-bit sprite indices.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 2;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // {R4,G4,B4}, classic 16-colour set; index 0 is never drawn (background).
  localparam logic [11:0] PALETTE [0:15] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider plus horizontal/vertical scan counters, with the raw
// (unregistered) sync and active-area decodes of the current position.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLK,
  input  logic       RST_N,
  output logic       tick_o,
  output logic       h_wrap_o,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       hsync_raw_o,
  output logic       vsync_raw_o,
  output logic       active_o
);

  localparam int LINE_TICKS  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(LINE_TICKS - 1);
  localparam logic [9:0] V_LAST   = 10'(FRAME_LINES - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             tick;
  logic             h_wrap;

  assign tick   = (div_q == DIV_LAST);
  assign h_wrap = (h_q == H_LAST);

  // Next-state for divider and scan position; line and frame wrap share one tick.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    div_d = tick ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Counter state; reset is asynchronous so a mid-frame reset restarts at (0,0) at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      // NOTE: non-blocking so all registers update from pre-edge values together.
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign tick_o      = tick;
  assign h_wrap_o    = h_wrap;
  assign h_o         = h_q;
  assign v_o         = v_q;
  assign hsync_raw_o = !((h_q >= HS_START) && (h_q < HS_END));
  assign vsync_raw_o = !((v_q >= VS_START) && (v_q < VS_END));
  assign active_o    = (h_q < H_ACT) && (v_q < V_ACT);

endmodule

// File: rtl/score_scan_driver.sv
// Scan-side driver for one 4-bit indexed sprite reader: issues the window
// request (is_in_pixel, hc, vc), samples the returned index and produces
// registered RGB and syncs, all one pixel tick behind the scan position.
module score_scan_driver
  import vga_pkg::*;
#(
  parameter int          CLK_DIV  = DEF_CLK_DIV,
  parameter int          H_ACTIVE = DEF_H_ACTIVE,
  parameter int          H_FP     = DEF_H_FP,
  parameter int          H_SYNC   = DEF_H_SYNC,
  parameter int          H_BP     = DEF_H_BP,
  parameter int          V_ACTIVE = DEF_V_ACTIVE,
  parameter int          V_FP     = DEF_V_FP,
  parameter int          V_SYNC   = DEF_V_SYNC,
  parameter int          V_BP     = DEF_V_BP,
  parameter int          SPR_X    = 0,
  parameter int          SPR_Y    = 0,
  parameter int          SPR_W    = 88,
  parameter int          SPR_H    = 20,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  pixel,
  output logic [9:0]  hc,
  output logic [9:0]  vc,
  output logic        is_in_pixel,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam logic [9:0] SPR_X10 = 10'(SPR_X);
  localparam logic [9:0] SPR_Y10 = 10'(SPR_Y);
  localparam logic [9:0] SPR_W10 = 10'(SPR_W);
  localparam logic [9:0] SPR_H10 = 10'(SPR_H);

  logic       tick;
  logic       h_wrap_unused;  // line-wrap strobe; frame start is decoded from h/v directly
  logic [9:0] h, v;
  logic       hsync_raw, vsync_raw, active;

  vga_timing_gen #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .tick_o      (tick),
    .h_wrap_o    (h_wrap_unused),
    .h_o         (h),
    .v_o         (v),
    .hsync_raw_o (hsync_raw),
    .vsync_raw_o (vsync_raw),
    .active_o    (active)
  );

  // Window test via unsigned offset: a position left of/above the origin wraps
  // to a large offset and fails the width/height compare on its own.
  logic [9:0] x_off, y_off;
  logic       in_win;

  assign x_off  = h - SPR_X10;
  assign y_off  = v - SPR_Y10;
  assign in_win = (x_off < SPR_W10) && (y_off < SPR_H10) && active;

  assign is_in_pixel = in_win;
  assign hc          = in_win ? x_off : '0;
  assign vc          = in_win ? y_off : '0;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;
  logic [11:0] rgb_q, rgb_d;
  logic        frame_start_q, frame_start_d;

  // Colour and sync values for the position currently being requested.
  always_comb begin
    hsync_d       = hsync_raw;
    vsync_d       = vsync_raw;
    video_on_d    = active;
    frame_start_d = tick && (h == '0) && (v == '0);
    rgb_d         = '0;
    if (active) begin
      if (in_win && (pixel != 4'd0)) rgb_d = PALETTE[pixel];
      else                           rgb_d = BG_RGB;
    end
  end

  // Output registers: capture on the tick that also advances h; frame_start lasts one CLK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
      if (tick) begin
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
        video_on_q <= video_on_d;
        rgb_q      <= rgb_d;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_score_scan_driver.sv
// Directed bench for score_scan_driver: default horizontal timing, a short
// vertical frame (30 lines) and a sprite window at (100,2) of 88x20.
module tb_score_scan_driver;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  pixel;
  logic [9:0]  hc, vc;
  logic        is_in_pixel, hsync, vsync, video_on, frame_start;
  logic [11:0] rgb;

  int vectors     = 0;
  int miscompares = 0;
  int k           = 0;  // ticks since reset release; after tick k the scan sits at k mod 800

  score_scan_driver #(
    .CLK_DIV  (2),
    .V_ACTIVE (24),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2),
    .SPR_X    (100),
    .SPR_Y    (2),
    .SPR_W    (88),
    .SPR_H    (20),
    .BG_RGB   (12'h123)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .pixel       (pixel),
    .hc          (hc),
    .vc          (vc),
    .is_in_pixel (is_in_pixel),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_tick();
    repeat (2) @(posedge CLK);
    #1;
    k++;
  endtask

  task automatic goto_tick(input int target);
    while (k < target) next_tick();
  endtask

  // Release reset on a falling edge; first tick lands on the second rising edge.
  task automatic release_reset(input string tag);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check({tag, "_no_tick_yet_video_on"}, video_on, 0);
    check({tag, "_no_tick_yet_fs"}, frame_start, 0);
    @(posedge CLK); #1;
    k = 1;
    check({tag, "_first_tick_fs"}, frame_start, 1);
    check({tag, "_first_tick_video_on"}, video_on, 1);
    check({tag, "_first_tick_rgb_bg"}, rgb, 12'h123);
    check({tag, "_first_tick_hsync"}, hsync, 1);
  endtask

  // Called right after tick 1; observes ticks 1..800 then the first tick of line 1.
  task automatic measure_line(input string tag);
    int vid_cnt, hs_cnt, hs_first;
    vid_cnt = 0; hs_cnt = 0; hs_first = 0;
    for (int t = 1; t <= 800; t++) begin
      if (video_on) vid_cnt++;
      if (!hsync) begin
        hs_cnt++;
        if (hs_first == 0) hs_first = t;
      end
      if (t == 700) check({tag, "_rgb_blank"}, rgb, 0);
      if (t == 1) begin
        @(posedge CLK); #1;
        check({tag, "_fs_one_clk"}, frame_start, 0);
        check({tag, "_hold_between_ticks"}, video_on, 1);
        @(posedge CLK); #1;
        k++;
      end else begin
        next_tick();
      end
    end
    check({tag, "_video_on_ticks"}, vid_cnt, 640);
    check({tag, "_hsync_low_ticks"}, hs_cnt, 96);
    check({tag, "_hsync_first_low_tick"}, hs_first, 657);
    check({tag, "_next_line_video_on"}, video_on, 1);
    check({tag, "_next_line_hsync"}, hsync, 1);
    check({tag, "_next_line_fs"}, frame_start, 0);
  endtask

  initial begin
    int vs_cnt, vs_first, fs_cnt;
    RST_N = 1'b0;
    pixel = 4'h0;

    // Reset held
    repeat (3) @(posedge CLK);
    #1;
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", rgb, 0);
    check("rst_video_on", video_on, 0);
    check("rst_fs", frame_start, 0);
    check("rst_in_pixel", is_in_pixel, 0);
    check("rst_hc", hc, 0);
    check("rst_vc", vc, 0);

    release_reset("rel");
    measure_line("line0");

    // Window edges and colour on line 8 (vc = 6)
    goto_tick(8 * 800 + 99);
    pixel = 4'hF;
    check("h99_in_pixel", is_in_pixel, 0);
    check("h99_hc", hc, 0);
    check("h99_vc", vc, 0);
    next_tick();
    check("h99_rgb_bg", rgb, 12'h123);
    check("h100_in_pixel", is_in_pixel, 1);
    check("h100_hc", hc, 0);
    check("h100_vc", vc, 6);
    goto_tick(8 * 800 + 105);
    check("h105_in_pixel", is_in_pixel, 1);
    check("h105_hc", hc, 5);
    check("h105_vc", vc, 6);
    next_tick();
    check("h105_rgb_pal15", rgb, 12'hFFF);
    pixel = 4'h0;
    next_tick();
    check("h106_rgb_index0_bg", rgb, 12'h123);
    pixel = 4'h9;
    next_tick();
    check("h107_rgb_pal9", rgb, 12'h55F);
    pixel = 4'hF;
    goto_tick(8 * 800 + 187);
    check("h187_in_pixel", is_in_pixel, 1);
    check("h187_hc", hc, 87);
    next_tick();
    check("h187_rgb_pal15", rgb, 12'hFFF);
    check("h188_in_pixel", is_in_pixel, 0);
    check("h188_hc", hc, 0);
    check("h188_vc", vc, 0);
    next_tick();
    check("h188_rgb_bg", rgb, 12'h123);
    pixel = 4'h0;

    // Rest of the frame: vsync on lines 26-27, single frame_start at wrap
    vs_cnt = 0; vs_first = 0; fs_cnt = 0;
    while (k < 30 * 800) begin
      next_tick();
      if (!vsync) begin
        vs_cnt++;
        if (vs_first == 0) vs_first = k;
      end
      if (frame_start) fs_cnt++;
    end
    check("vsync_low_ticks", vs_cnt, 1600);
    check("vsync_first_low_tick", vs_first, 26 * 800 + 1);
    check("no_fs_mid_frame", fs_cnt, 0);
    check("frame_end_vsync", vsync, 1);
    check("frame_end_video_on", video_on, 0);
    next_tick();
    check("frame_wrap_fs", frame_start, 1);
    check("frame_wrap_video_on", video_on, 1);

    // Asynchronous reset at h=400, v=10 of the second frame
    goto_tick(30 * 800 + 10 * 800 + 400);
    check("pre_rst_video_on", video_on, 1);
    check("pre_rst_rgb", rgb, 12'h123);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_video_on", video_on, 0);
    check("async_rst_rgb", rgb, 0);
    check("async_rst_hsync", hsync, 1);
    check("async_rst_vsync", vsync, 1);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_hold_video_on", video_on, 0);
    check("rst_hold_fs", frame_start, 0);
    release_reset("rerel");
    measure_line("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
